// File: rtl/associative_memory_pkg.sv
// Shared types and defaults for the associative memory (HD classifier back end).
// Parameter defaults mirror the encoder build; instantiators may override them.
package associative_memory_pkg;

    localparam int DEFAULT_HV_DIMENSION = 1024;
    localparam int DEFAULT_CLASSES      = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_OUTPUT = 2'd2
    } am_state_e;

    // A single-class memory still needs a 1-bit label/index.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/associative_memory_hamming_distance.sv
// Combinational Hamming distance between two hypervectors.
// Computed as XOR followed by a ripple popcount.
module hamming_distance #(
    parameter int HV_DIMENSION = 1024,
    parameter int DIST_WIDTH   = $clog2(HV_DIMENSION + 1)
) (
    input  logic [0:HV_DIMENSION-1] A_DI,
    input  logic [0:HV_DIMENSION-1] B_DI,
    output logic [DIST_WIDTH-1:0]   Dist_DO
);

    logic [0:HV_DIMENSION-1] diff;
    logic [DIST_WIDTH-1:0]   count;

    assign diff = A_DI ^ B_DI;

    always_comb begin
        count = '0;
        for (int i = 0; i < HV_DIMENSION; i++) begin
            count = count + DIST_WIDTH'(diff[i]);
        end
    end

    assign Dist_DO = count;

endmodule

// File: rtl/associative_memory.sv
// Associative memory: sequential minimum-Hamming-distance search over stored prototypes,
// one class per cycle, with a host write port for loading prototypes while idle.
module associative_memory
    import associative_memory_pkg::*;
#(
    parameter int HV_DIMENSION = DEFAULT_HV_DIMENSION,
    parameter int CLASSES      = DEFAULT_CLASSES,
    parameter int LABEL_WIDTH  = index_width(CLASSES),
    parameter int DIST_WIDTH   = $clog2(HV_DIMENSION + 1)
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
    output logic [DIST_WIDTH-1:0]   DistanceOut_DO,
    input  logic                    ProtoWrEn_SI,
    input  logic [LABEL_WIDTH-1:0]  ProtoAddr_DI,
    input  logic [0:HV_DIMENSION-1] ProtoData_DI,
    output am_state_e               StateDbg_SO
);

    localparam logic [LABEL_WIDTH-1:0] LAST_IDX = LABEL_WIDTH'(CLASSES - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Upstream: ReadyOut_SO is high only in IDLE. Downstream: ValidOut_SO is high only in
    // OUTPUT and the result is held there, unchanged, until ReadyIn_SI completes the transfer.

    am_state_e               state_q;
    logic [0:HV_DIMENSION-1] proto_q [CLASSES];
    logic [0:HV_DIMENSION-1] query_q;
    logic [LABEL_WIDTH-1:0]  idx_q;
    logic [DIST_WIDTH-1:0]   min_dist_q, min_dist_d;
    logic [LABEL_WIDTH-1:0]  label_q, label_d;
    logic [LABEL_WIDTH-1:0]  label_out_q;
    logic [DIST_WIDTH-1:0]   dist_out_q;
    logic [DIST_WIDTH-1:0]   cur_dist;
    logic                    cand_better;
    logic                    wr_addr_ok;

    hamming_distance #(
        .HV_DIMENSION (HV_DIMENSION),
        .DIST_WIDTH   (DIST_WIDTH)
    ) u_hamming (
        .A_DI    (query_q),
        .B_DI    (proto_q[idx_q]),
        .Dist_DO (cur_dist)
    );

    // Strict compare keeps the lowest index on ties.
    assign cand_better = (cur_dist < min_dist_q);
    assign min_dist_d  = cand_better ? cur_dist : min_dist_q;
    assign label_d     = cand_better ? idx_q : label_q;
    assign wr_addr_ok  = (int'(ProtoAddr_DI) < CLASSES);

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state_q     <= ST_IDLE;
            query_q     <= '0;
            idx_q       <= '0;
            min_dist_q  <= '0;
            label_q     <= '0;
            label_out_q <= '0;
            dist_out_q  <= '0;
            for (int i = 0; i < CLASSES; i++) begin
                proto_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ProtoWrEn_SI && wr_addr_ok) begin
                        proto_q[ProtoAddr_DI] <= ProtoData_DI;
                    end
                    if (ValidIn_SI) begin
                        query_q    <= HypervectorIn_DI;
                        idx_q      <= '0;
                        min_dist_q <= '1;
                        label_q    <= '0;
                        state_q    <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    min_dist_q <= min_dist_d;
                    label_q    <= label_d;
                    if (idx_q == LAST_IDX) begin
                        // Result registers are separate so they survive the next query's init.
                        label_out_q <= label_d;
                        dist_out_q  <= min_dist_d;
                        state_q     <= ST_OUTPUT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (ReadyIn_SI) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReadyOut_SO    = (state_q == ST_IDLE);
    assign ValidOut_SO    = (state_q == ST_OUTPUT);
    assign LabelOut_DO    = label_out_q;
    assign DistanceOut_DO = dist_out_q;
    assign StateDbg_SO    = state_q;

endmodule

// File: tb/tb_associative_memory.sv
// Directed and randomized bench for associative_memory (HV_DIMENSION=16, CLASSES=4)
// against a brute-force minimum-distance reference model.
module tb_associative_memory;
    import associative_memory_pkg::*;

    localparam int HV  = 16;
    localparam int NC  = 4;
    localparam int LW  = 2;
    localparam int DW  = 5;
    localparam int RW  = LW + DW;
    localparam int LAT = NC + 1;
    localparam int NB2B = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [HV-1:0] hv_in = '0;
    logic          valid_out;
    logic          ready_in = 1'b1;
    logic [LW-1:0] label_out;
    logic [DW-1:0] dist_out;
    logic          wr_en = 1'b0;
    logic [LW-1:0] wr_addr = '0;
    logic [HV-1:0] wr_data = '0;
    am_state_e     state_dbg;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;

    logic [HV-1:0] m_proto [NC];
    logic [RW-1:0] exp_q[$];

    associative_memory #(
        .HV_DIMENSION (HV),
        .CLASSES      (NC)
    ) dut (
        .Clk_CI           (clk),
        .Reset_RI         (reset),
        .ValidIn_SI       (valid_in),
        .ReadyOut_SO      (ready_out),
        .HypervectorIn_DI (hv_in),
        .ValidOut_SO      (valid_out),
        .ReadyIn_SI       (ready_in),
        .LabelOut_DO      (label_out),
        .DistanceOut_DO   (dist_out),
        .ProtoWrEn_SI     (wr_en),
        .ProtoAddr_DI     (wr_addr),
        .ProtoData_DI     (wr_data),
        .StateDbg_SO      (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    // Reference model: exhaustive scan, first strictly smaller distance wins.
    function automatic logic [RW-1:0] ref_result(input logic [HV-1:0] q);
        int best_d;
        int best_l;
        int d;
        best_d = HV + 1;
        best_l = 0;
        for (int c = 0; c < NC; c++) begin
            d = $countones(q ^ m_proto[c]);
            if (d < best_d) begin
                best_d = d;
                best_l = c;
            end
        end
        return {LW'(best_l), DW'(best_d)};
    endfunction

    function automatic logic [HV-1:0] rand_query();
        logic [HV-1:0] one;
        one = HV'(1);
        if ($urandom_range(0, 1) == 1)
            return m_proto[$urandom_range(0, NC - 1)] ^ (one << $urandom_range(0, HV - 1));
        return HV'($urandom());
    endfunction

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [HV-1:0] q);
        logic [RW-1:0] r;
        r = ref_result(q);
        check({tag, "_label"}, 32'(label_out), 32'(r[RW-1:DW]));
        check({tag, "_dist"}, 32'(dist_out), 32'(r[DW-1:0]));
    endtask

    // Drivers
    task automatic load_proto(input int addr, input logic [HV-1:0] data);
        wr_en = 1'b1;
        wr_addr = LW'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
        m_proto[addr] = data;
    endtask

    task automatic send_query(input logic [HV-1:0] q);
        valid_in = 1'b1;
        hv_in = q;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int cyc);
        cyc = start;
        while (!valid_out && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_query(input string tag, input logic [HV-1:0] q);
        int lat;
        logic [RW-1:0] r;
        r = ref_result(q);
        send_query(q);
        wait_valid(1, lat);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check_result(tag, q);
        tick();
        check({tag, "_ready_after"}, 32'(ready_out), 32'd1);
        check({tag, "_hold_label"}, 32'(label_out), 32'(r[RW-1:DW]));
        check({tag, "_hold_dist"}, 32'(dist_out), 32'(r[DW-1:0]));
    endtask

    initial begin
        int lat;
        int n_sent;
        int n_got;
        int last_cyc;
        logic acc;
        logic [HV-1:0] q;
        logic [HV-1:0] q2;
        logic [LW-1:0] held_l;
        logic [DW-1:0] held_d;
        logic [RW-1:0] e;

        for (int c = 0; c < NC; c++) m_proto[c] = '0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(ready_out), 32'd1);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_label", 32'(label_out), 32'd0);
        check("rst_dist", 32'(dist_out), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // 1: basic search
        load_proto(0, 16'h0000);
        load_proto(1, 16'hFFFF);
        load_proto(2, 16'h00FF);
        load_proto(3, 16'hF0F0);
        send_query(16'h00FE);
        check("t1_busy_ready", 32'(ready_out), 32'd0);
        check("t1_busy_state", 32'(state_dbg), 32'(ST_SEARCH));
        check("t1_busy_valid", 32'(valid_out), 32'd0);
        wait_valid(1, lat);
        check("t1_latency", 32'(lat), 32'(LAT));
        check_result("t1", 16'h00FE);
        tick();
        check("t1_ready_after", 32'(ready_out), 32'd1);
        check("t1_valid_after", 32'(valid_out), 32'd0);

        // 2: ties resolve to the lowest index
        load_proto(0, 16'h000F);
        load_proto(1, 16'h000F);
        load_proto(2, 16'hFFFF);
        load_proto(3, 16'hFFFF);
        do_query("t2", 16'h0000);

        // 3: backpressure holds the result and blocks new queries
        load_proto(0, 16'h1234);
        load_proto(1, 16'h5678);
        load_proto(2, 16'h9ABC);
        load_proto(3, 16'hDEF0);
        q = rand_query();
        q2 = rand_query();
        ready_in = 1'b0;
        send_query(q);
        wait_valid(1, lat);
        check("t3_latency", 32'(lat), 32'(LAT));
        check_result("t3", q);
        held_l = label_out;
        held_d = dist_out;
        valid_in = 1'b1;
        hv_in = q2;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_bp_valid", 32'(valid_out), 32'd1);
            check("t3_bp_ready", 32'(ready_out), 32'd0);
            check_result("t3_bp", q);
        end
        ready_in = 1'b1;
        tick();
        check("t3_idle_ready", 32'(ready_out), 32'd1);
        check("t3_idle_valid", 32'(valid_out), 32'd0);
        check("t3_idle_label", 32'(label_out), 32'(held_l));
        check("t3_idle_dist", 32'(dist_out), 32'(held_d));
        tick();
        valid_in = 1'b0;
        check("t3_q2_accepted", 32'(state_dbg), 32'(ST_SEARCH));
        wait_valid(1, lat);
        check("t3_q2_latency", 32'(lat), 32'(LAT));
        check_result("t3_q2", q2);
        tick();

        // 4: writes during SEARCH are ignored; in IDLE they apply
        q = 16'h0F0F;
        send_query(q);
        tick();
        wr_en = 1'b1;
        wr_addr = 2'd2;
        wr_data = q;
        tick();
        wr_en = 1'b0;
        wait_valid(3, lat);
        check("t4_latency", 32'(lat), 32'(LAT));
        check_result("t4_ignored", q);
        tick();
        load_proto(2, q);
        do_query("t4_applied", q);

        // Write and query in the same IDLE cycle: search sees the new prototype
        q2 = 16'hA5C3;
        wr_en = 1'b1;
        wr_addr = 2'd1;
        wr_data = q2;
        m_proto[1] = q2;
        send_query(q2);
        wr_en = 1'b0;
        wait_valid(1, lat);
        check("t4_same_cycle_latency", 32'(lat), 32'(LAT));
        check_result("t4_same_cycle", q2);
        tick();

        // 5: reset in the second SEARCH cycle
        send_query(rand_query());
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < NC; c++) m_proto[c] = '0;
        check("t5_valid", 32'(valid_out), 32'd0);
        check("t5_ready", 32'(ready_out), 32'd1);
        check("t5_label", 32'(label_out), 32'd0);
        check("t5_dist", 32'(dist_out), 32'd0);
        do_query("t5_cleared", HV'($urandom()));

        // 6: back-to-back random queries with ValidIn held high
        for (int c = 0; c < NC; c++) load_proto(c, HV'($urandom()));
        ready_in = 1'b1;
        n_sent = 0;
        n_got = 0;
        last_cyc = -1;
        valid_in = 1'b1;
        hv_in = rand_query();
        for (int k = 0; k < 400 && n_got < NB2B; k++) begin
            acc = ready_out && valid_in;
            tick();
            if (acc) begin
                exp_q.push_back(ref_result(hv_in));
                n_sent++;
                if (n_sent < NB2B) hv_in = rand_query();
                else valid_in = 1'b0;
            end
            if (valid_out) begin
                check("b2b_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("b2b_label", 32'(label_out), 32'(e[RW-1:DW]));
                    check("b2b_dist", 32'(dist_out), 32'(e[DW-1:0]));
                    if (last_cyc >= 0) check("b2b_period", 32'(cyc_cnt - last_cyc), 32'(NC + 2));
                    last_cyc = cyc_cnt;
                    n_got++;
                end
            end
        end
        valid_in = 1'b0;
        check("b2b_count", 32'(n_got), 32'(NB2B));
        check("b2b_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
